// File: rtl/packet_snooper.sv
// rtl/packet_snooper.sv - captures one stream packet into a word-addressed buffer, then pulses done.
// Optional statistics counters (pkt_count, trunc_count) are built when SNOOPER_STATS_EN is defined.
module packet_snooper #(
  parameter int SNOOP_FWD_ADDR_WIDTH = 9,
  parameter int SNOOP_FWD_DATA_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [SNOOP_FWD_DATA_WIDTH-1:0] sn_TDATA,
  input  logic                            sn_TVALID,
  input  logic                            sn_TLAST,
  output logic                            sn_TREADY,
  input  logic                            ready_for_snooper,
  output logic [SNOOP_FWD_ADDR_WIDTH-1:0] snooper_wr_addr,
  output logic [SNOOP_FWD_DATA_WIDTH-1:0] snooper_wr_data,
  output logic                            snooper_wr_en,
  output logic                            snooper_done
`ifdef SNOOPER_STATS_EN
  ,
  output logic [31:0]                     pkt_count,
  output logic [31:0]                     trunc_count
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RECV   = 3'd1,
    FLUSH  = 3'd2,
    FINISH = 3'd3,
    DONE   = 3'd4,
    WAIT   = 3'd5
  } state_t;

  localparam logic [SNOOP_FWD_ADDR_WIDTH-1:0] CNT_MAX = '1;

  state_t                            state_q, state_d;
  logic [SNOOP_FWD_ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                              wr_en_q, wr_en_d;
  logic [SNOOP_FWD_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [SNOOP_FWD_DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                              hs;

  // Ready depends only on registered state, never on TVALID.
  assign sn_TREADY       = (state_q == RECV) || (state_q == FLUSH);
  assign snooper_done    = (state_q == DONE);
  assign snooper_wr_en   = wr_en_q;
  assign snooper_wr_addr = wr_addr_q;
  assign snooper_wr_data = wr_data_q;
  assign hs              = sn_TVALID && sn_TREADY;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (ready_for_snooper) begin
          state_d = RECV;
          cnt_d   = '0;
        end
      end
      RECV: begin
        if (hs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = sn_TDATA;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          // The last word of the buffer may also be the last beat.
          if (sn_TLAST) begin
            state_d = FINISH;
          end else if (cnt_q == CNT_MAX) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (hs && sn_TLAST) begin
          state_d = FINISH;
        end
      end
      FINISH:  state_d = DONE;
      DONE:    state_d = WAIT;
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

`ifdef SNOOPER_STATS_EN
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [31:0] trunc_count_q, trunc_count_d;

  always_comb begin
    pkt_count_d   = pkt_count_q;
    trunc_count_d = trunc_count_q;
    if (state_q == FINISH) begin
      pkt_count_d = pkt_count_q + 32'd1;
    end
    if ((state_q == RECV) && (state_d == FLUSH)) begin
      trunc_count_d = trunc_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_q   <= '0;
      trunc_count_q <= '0;
    end else begin
      pkt_count_q   <= pkt_count_d;
      trunc_count_q <= trunc_count_d;
    end
  end

  assign pkt_count   = pkt_count_q;
  assign trunc_count = trunc_count_q;
`endif

endmodule

// File: tb/tb_packet_snooper.sv
// tb/tb_packet_snooper.sv - self-checking bench for packet_snooper (4-word buffer).
// Honours SNOOPER_STATS_EN to connect and check the statistics ports.
module tb_packet_snooper;
  localparam int AW = 2;
  localparam int DW = 64;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] sn_TDATA = '0;
  logic          sn_TVALID = 1'b0;
  logic          sn_TLAST = 1'b0;
  logic          sn_TREADY;
  logic          ready_for_snooper = 1'b0;
  logic [AW-1:0] snooper_wr_addr;
  logic [DW-1:0] snooper_wr_data;
  logic          snooper_wr_en;
  logic          snooper_done;
`ifdef SNOOPER_STATS_EN
  logic [31:0]   pkt_count;
  logic [31:0]   trunc_count;
`endif

  packet_snooper #(.SNOOP_FWD_ADDR_WIDTH(AW), .SNOOP_FWD_DATA_WIDTH(DW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sn_TDATA(sn_TDATA),
    .sn_TVALID(sn_TVALID),
    .sn_TLAST(sn_TLAST),
    .sn_TREADY(sn_TREADY),
    .ready_for_snooper(ready_for_snooper),
    .snooper_wr_addr(snooper_wr_addr),
    .snooper_wr_data(snooper_wr_data),
    .snooper_wr_en(snooper_wr_en),
    .snooper_done(snooper_done)
`ifdef SNOOPER_STATS_EN
    ,
    .pkt_count(pkt_count),
    .trunc_count(trunc_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rdy, vld, lst;
    logic [DW-1:0] dat;
    logic          etr, een;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          edn;
  } vec_t;

  vec_t          tbl[$];
  int            checks = 0;
  int            failures = 0;
  int            done_cnt = 0;
  logic [AW-1:0] wq_addr[$];
  logic [DW-1:0] wq_data[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (snooper_wr_en) begin
        wq_addr.push_back(snooper_wr_addr);
        wq_data.push_back(snooper_wr_data);
      end
      if (snooper_done) done_cnt++;
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic v, input logic l, input logic [DW-1:0] d,
                              input logic etr, input logic een, input logic [AW-1:0] ea,
                              input logic [DW-1:0] ed, input logic edn);
    vec_t t;
    t.rdy = r; t.vld = v; t.lst = l; t.dat = d;
    t.etr = etr; t.een = een; t.ea = ea; t.ed = ed; t.edn = edn;
    tbl.push_back(t);
  endfunction

  function automatic void idle_row(input logic r, input logic edn);
    add(r, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, edn);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int            base_done;
    int            len, idx, cyc, nexp, base_w, exp_trunc;
    logic [DW-1:0] beats[8];

    // Three-beat packet A,B,C
    idle_row(1, 0);
    add(1, 1, 0, 'hA, 1, 0, 0, 0,   0);
    add(1, 1, 0, 'hB, 1, 1, 0, 'hA, 0);
    add(1, 1, 1, 'hC, 1, 1, 1, 'hB, 0);
    add(1, 0, 0, 0,   0, 1, 2, 'hC, 0);
    idle_row(1, 1);
    idle_row(0, 0);
    idle_row(0, 0);
    // No buffer owned: valid beats must be refused
    for (int i = 0; i < 10; i++) add(0, 1, 0, 'hEE, 0, 0, 0, 0, 0);
    add(1, 1, 0, 'hEE, 0, 0, 0, 0,   0);
    add(1, 1, 1, 'hD,  1, 0, 0, 0,   0);
    add(0, 0, 0, 0,    0, 1, 0, 'hD, 0);
    idle_row(0, 1);
    idle_row(0, 0);
    idle_row(0, 0);
    // TVALID toggling, ready dropped mid-packet
    idle_row(1, 0);
    add(0, 1, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 1, 0);
    add(0, 1, 0, 2, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 1, 2, 0);
    add(0, 1, 0, 3, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1, 2, 3, 0);
    add(0, 1, 1, 4, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 3, 4, 0);
    idle_row(0, 1);
    idle_row(0, 0);
    idle_row(0, 0);
    // Six beats into a four-word buffer
    idle_row(1, 0);
    add(0, 1, 0, 'h21, 1, 0, 0, 0,     0);
    add(0, 1, 0, 'h22, 1, 1, 0, 'h21,  0);
    add(0, 1, 0, 'h23, 1, 1, 1, 'h22,  0);
    add(0, 1, 0, 'h24, 1, 1, 2, 'h23,  0);
    add(0, 1, 0, 'h25, 1, 1, 3, 'h24,  0);
    add(0, 1, 1, 'h26, 1, 0, 0, 0,     0);
    idle_row(0, 0);
    idle_row(0, 1);
    idle_row(0, 0);
    idle_row(0, 0);
    // Back-to-back packets with ready held high
    idle_row(1, 0);
    add(1, 1, 1, 'h11, 1, 0, 0, 0,     0);
    add(1, 0, 0, 0,    0, 1, 0, 'h11,  0);
    idle_row(1, 1);
    idle_row(1, 0);
    idle_row(1, 0);
    add(1, 1, 1, 'h22, 1, 0, 0, 0,     0);
    add(0, 0, 0, 0,    0, 1, 0, 'h22,  0);
    idle_row(0, 1);
    idle_row(0, 0);
    idle_row(0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", sn_TREADY, 0);
    chk("rst_wr_en", snooper_wr_en, 0);
    chk("rst_wr_addr", snooper_wr_addr, 0);
    chk("rst_wr_data", snooper_wr_data, 0);
    chk("rst_done", snooper_done, 0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      ready_for_snooper = tbl[i].rdy;
      sn_TVALID = tbl[i].vld;
      sn_TLAST = tbl[i].lst;
      sn_TDATA = tbl[i].dat;
      @(negedge clk);
      chk($sformatf("vec%0d_tready", i), sn_TREADY, tbl[i].etr);
      chk($sformatf("vec%0d_wr_en", i), snooper_wr_en, tbl[i].een);
      chk($sformatf("vec%0d_done", i), snooper_done, tbl[i].edn);
      if (tbl[i].een) begin
        chk($sformatf("vec%0d_addr", i), snooper_wr_addr, tbl[i].ea);
        chk($sformatf("vec%0d_data", i), snooper_wr_data, tbl[i].ed);
      end
    end
`ifdef SNOOPER_STATS_EN
    chk("tbl_pkt_count", pkt_count, 6);
    chk("tbl_trunc_count", trunc_count, 1);
`endif

    // Reset after the second of five beats
    @(posedge clk); #1;
    ready_for_snooper = 1'b1;
    @(posedge clk); #1;
    sn_TVALID = 1'b1; sn_TLAST = 1'b0; sn_TDATA = 'h51;
    @(posedge clk); #1;
    sn_TDATA = 'h52;
    @(posedge clk); #1;
    base_done = done_cnt;
    rst_n = 1'b0;
    sn_TVALID = 1'b0;
    ready_for_snooper = 1'b0;
    #1;
    chk("midrst_tready", sn_TREADY, 0);
    chk("midrst_wr_en", snooper_wr_en, 0);
    chk("midrst_wr_addr", snooper_wr_addr, 0);
    chk("midrst_wr_data", snooper_wr_data, 0);
    chk("midrst_done", snooper_done, 0);
`ifdef SNOOPER_STATS_EN
    chk("midrst_pkt_count", pkt_count, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ready_for_snooper = 1'b1;
    @(negedge clk);
    chk("postrst_idle_tready", sn_TREADY, 0);
    @(posedge clk); #1;
    sn_TVALID = 1'b1; sn_TLAST = 1'b1; sn_TDATA = 'h61;
    @(negedge clk);
    chk("postrst_tready", sn_TREADY, 1);
    @(posedge clk); #1;
    sn_TVALID = 1'b0; sn_TLAST = 1'b0; ready_for_snooper = 1'b0;
    @(negedge clk);
    chk("postrst_wr_en", snooper_wr_en, 1);
    chk("postrst_wr_addr", snooper_wr_addr, 0);
    chk("postrst_wr_data", snooper_wr_data, 'h61);
    chk("postrst_no_done", done_cnt, base_done);
    @(negedge clk);
    chk("postrst_done", snooper_done, 1);
    repeat (3) @(posedge clk);

    // Randomized packets against a buffer-capture model
    exp_trunc = 0;
    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(1, 8);
      for (int b = 0; b < 8; b++) beats[b] = {$urandom, $urandom};
      base_w = wq_addr.size();
      base_done = done_cnt;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        ready_for_snooper = 1'b0;
        sn_TVALID = ($urandom % 2) != 0;
        sn_TDATA = {$urandom, $urandom};
        sn_TLAST = 1'b0;
      end
      idx = 0;
      cyc = 0;
      while (idx < len && cyc < 200) begin
        @(posedge clk); #1;
        ready_for_snooper = ($urandom % 4) != 0;
        sn_TVALID = ($urandom % 3) != 0;
        sn_TDATA = beats[idx];
        sn_TLAST = (idx == len - 1);
        @(negedge clk);
        if (sn_TVALID && sn_TREADY) idx++;
        cyc++;
      end
      @(posedge clk); #1;
      sn_TVALID = 1'b0;
      sn_TLAST = 1'b0;
      ready_for_snooper = 1'b0;
      for (int w = 0; w < 20 && done_cnt == base_done; w++) @(negedge clk);
      chk($sformatf("rnd%0d_done", p), done_cnt, base_done + 1);
      nexp = (len < DEPTH) ? len : DEPTH;
      if (len > DEPTH) exp_trunc++;
      chk($sformatf("rnd%0d_nwrites", p), wq_addr.size() - base_w, nexp);
      for (int k = 0; k < nexp && base_w + k < wq_addr.size(); k++) begin
        chk($sformatf("rnd%0d_addr%0d", p, k), wq_addr[base_w + k], k);
        chk($sformatf("rnd%0d_data%0d", p, k), wq_data[base_w + k], beats[k]);
      end
      repeat (2) @(posedge clk);
    end
`ifdef SNOOPER_STATS_EN
    chk("rnd_pkt_count", pkt_count, 31);
    chk("rnd_trunc_count", trunc_count, exp_trunc);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/packet_snooper.md
PACKET_SNOOPER -- requirements
Module: packet_snooper

Interface
REQ-001 SHALL have parameter SNOOP_FWD_ADDR_WIDTH, default 9, word address width into the packet buffer.
REQ-002 SHALL have parameter SNOOP_FWD_DATA_WIDTH, default 64, width of the stream data and of each buffer word.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sn_TDATA  input  SNOOP_FWD_DATA_WIDTH  stream beat data.
REQ-006 SHALL have port sn_TVALID  input  1  stream beat valid.
REQ-007 SHALL have port sn_TLAST  input  1  final beat of the packet.
REQ-008 SHALL have port sn_TREADY  output  1  beat accepted when TVALID and TREADY are both high.
REQ-009 SHALL have port ready_for_snooper  input  1  a packet buffer is owned by the snooper.
REQ-010 SHALL have port snooper_wr_addr  output  SNOOP_FWD_ADDR_WIDTH  buffer word address.
REQ-011 SHALL have port snooper_wr_data  output  SNOOP_FWD_DATA_WIDTH  buffer write data.
REQ-012 SHALL have port snooper_wr_en  output  1  buffer write strobe.
REQ-013 SHALL have port snooper_done  output  1  one-cycle pulse that hands the filled buffer onward.

Function
REQ-014 SHALL implement the states IDLE, RECV, FLUSH, FINISH, DONE and WAIT.
REQ-015 SHALL move IDLE->RECV when ready_for_snooper=1 and SHALL clear the word counter to 0 on that transition.
REQ-016 SHALL drive sn_TREADY=1 only in RECV and FLUSH, decoded from registered state with no combinational path from sn_TVALID.
REQ-017 SHALL, on a RECV handshake, drive snooper_wr_en=1, snooper_wr_addr=counter and snooper_wr_data=sn_TDATA in the next cycle (1-cycle latency), then increment the counter.
REQ-018 SHALL move RECV->FINISH on a handshake with sn_TLAST=1.
REQ-019 SHALL move RECV->FLUSH on a handshake with sn_TLAST=0 and counter=2^SNOOP_FWD_ADDR_WIDTH-1 (buffer full), so the counter never wraps.
REQ-020 SHALL accept and discard beats in FLUSH with snooper_wr_en held at 0, and SHALL move FLUSH->FINISH on a handshake with sn_TLAST=1.
REQ-021 SHALL move FINISH->DONE after one cycle; the final write (if any) completes in FINISH.
REQ-022 SHALL assert snooper_done=1 for exactly the one cycle spent in DONE, then move to WAIT.
REQ-023 SHALL spend one cycle in WAIT, ignoring ready_for_snooper, then return to IDLE, so a stale ready is never sampled.
REQ-024 SHALL NOT react to ready_for_snooper falling during RECV or FLUSH (buffer ownership is guaranteed until done).
REQ-025 SHALL NOT emit a write or a done pulse for a beat not handshaken (TVALID low stalls without side effects).

Reset
REQ-026 SHALL, while rst_n=0, force state=IDLE, counter=0, sn_TREADY=0, snooper_wr_en=0, snooper_done=0, snooper_wr_addr=0 and snooper_wr_data=0.
REQ-027 SHALL, on reset mid-packet, abandon the packet with no done pulse and SHALL resume from IDLE on the first edge after rst_n rises.

Configuration
REQ-028 SHALL, when SNOOPER_STATS_EN is defined, add output pkt_count (32 bits), counting DONE entries, and output trunc_count (32 bits), counting FLUSH entries; both are reset to 0 and wrap modulo 2^32.
REQ-029 SHALL, when SNOOPER_STATS_EN is not defined, omit both ports and the counter logic; all other behaviour SHALL be identical.

Verification
REQ-030 SHALL cover: ready=1, 3 beats 0xA,0xB,0xC with TLAST on 0xC -> writes addr 0,1,2 with data A,B,C one cycle after each handshake, done pulses once 2 cycles after the last handshake.
REQ-031 SHALL cover: ready=0 with TVALID=1 for 10 cycles -> TREADY=0 and no writes; ready rises -> TREADY=1 next cycle.
REQ-032 SHALL cover: ADDR_WIDTH=2, 6-beat packet -> writes addr 0..3 only, beats 5-6 discarded, one done pulse, trunc_count=1 with SNOOPER_STATS_EN.
REQ-033 SHALL cover: TVALID toggling every other cycle over 4 beats -> 4 consecutive addresses 0..3 with no gaps or duplicates.
REQ-034 SHALL cover: rst_n pulsed low after beat 2 of 5 -> outputs zero immediately, no done; next packet starts at addr 0.
REQ-035 SHALL cover: ready held at 1 across back-to-back packets -> TREADY low for DONE and WAIT cycles, second packet starts at addr 0, pkt_count=2.
